// File: rtl/div_unit_pkg.sv
// rtl/div_unit_pkg.sv - shared defines for the iterative divider
package div_unit_pkg;

   typedef enum logic [1:0] {
      DIV_IDLE   = 2'd0,
      DIV_BYZERO = 2'd1,
      DIV_ON     = 2'd2,
      DIV_END    = 2'd3
   } div_state_t;

   localparam logic DivStart    = 1'b1;
   localparam logic DivStop     = 1'b0;
   localparam logic DivSigned   = 1'b1;
   localparam logic DivUnsigned = 1'b0;

endpackage

// File: rtl/div_step.sv
// rtl/div_step.sv - one restoring shift/compare/subtract iteration
module div_step #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH:0]   rem_i,
   input  logic [WIDTH-1:0] quo_i,
   input  logic [WIDTH-1:0] divisor_i,
   output logic [WIDTH:0]   rem_o,
   output logic [WIDTH-1:0] quo_o
);

   logic [WIDTH:0] shifted;
   logic [WIDTH:0] diff;
   logic           ge;

   // quo_i doubles as the dividend shift register: its MSB feeds the remainder,
   // the new quotient bit enters at the LSB.
   always_comb begin
      shifted = {rem_i[WIDTH-1:0], quo_i[WIDTH-1]};
      diff    = shifted - {1'b0, divisor_i};
      ge      = rem_i[WIDTH] | (shifted >= {1'b0, divisor_i});
      rem_o   = ge ? diff : shifted;
      quo_o   = {quo_i[WIDTH-2:0], ge};
   end

endmodule

// File: rtl/div_unit.sv
// rtl/div_unit.sv - multi-cycle signed/unsigned divider for the execute stage
module div_unit
   import div_unit_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int CNT_W = $clog2(WIDTH) + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start_i,
   input  logic             annul_i,
   input  logic             signed_i,
   input  logic [WIDTH-1:0] dividend_i,
   input  logic [WIDTH-1:0] divisor_i,
   output logic             busy_o,
   output logic             ready_o,
   output logic [WIDTH-1:0] quotient_o,
   output logic [WIDTH-1:0] remainder_o,
   output logic             div_zero_o
);

   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

   div_state_t       state, next_state;
   logic [CNT_W-1:0] cnt;
   logic [WIDTH:0]   rem_q;
   logic [WIDTH-1:0] quo_q;
   logic [WIDTH-1:0] dvs_q;
   logic             neg_quo_q;
   logic             neg_rem_q;
   logic [WIDTH-1:0] quotient_q;
   logic [WIDTH-1:0] remainder_q;
   logic             div_zero_q;

   logic [WIDTH:0]   step_rem;
   logic [WIDTH-1:0] step_quo;
   logic             is_signed;
   logic             dd_neg;
   logic             dv_neg;

   assign is_signed = (signed_i == DivSigned);
   assign dd_neg    = is_signed & dividend_i[WIDTH-1];
   assign dv_neg    = is_signed & divisor_i[WIDTH-1];

   div_step #(.WIDTH(WIDTH)) u_step (
      .rem_i     (rem_q),
      .quo_i     (quo_q),
      .divisor_i (dvs_q),
      .rem_o     (step_rem),
      .quo_o     (step_quo)
   );

   always_ff @(posedge clk) begin
      if (rst) state <= DIV_IDLE;
      else     state <= next_state;
   end

   always_comb begin
      next_state = state;
      busy_o     = 1'b1;
      ready_o    = 1'b0;
      case (state)
         DIV_IDLE: begin
            busy_o = 1'b0;
            if (start_i == DivStart && !annul_i)
               next_state = (divisor_i == '0) ? DIV_BYZERO : DIV_ON;
         end
         DIV_BYZERO: next_state = annul_i ? DIV_IDLE : DIV_END;
         DIV_ON: begin
            if (annul_i)              next_state = DIV_IDLE;
            else if (cnt == LAST_CNT) next_state = DIV_END;
         end
         DIV_END: begin
            ready_o = 1'b1;
            if (annul_i || start_i == DivStop) next_state = DIV_IDLE;
         end
         default: next_state = DIV_IDLE;
      endcase
   end

   // Result registers are only loaded on the edge into END and cleared on the
   // way out, so the outputs read zero in every other state.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt         <= '0;
         rem_q       <= '0;
         quo_q       <= '0;
         dvs_q       <= '0;
         neg_quo_q   <= 1'b0;
         neg_rem_q   <= 1'b0;
         quotient_q  <= '0;
         remainder_q <= '0;
         div_zero_q  <= 1'b0;
      end else begin
         case (state)
            DIV_IDLE: begin
               if (start_i == DivStart && !annul_i) begin
                  cnt       <= '0;
                  rem_q     <= '0;
                  quo_q     <= dd_neg ? -dividend_i : dividend_i;
                  dvs_q     <= dv_neg ? -divisor_i  : divisor_i;
                  neg_quo_q <= (signed_i != DivUnsigned) & (dd_neg ^ dv_neg);
                  neg_rem_q <= dd_neg;
               end
            end
            DIV_BYZERO: begin
               if (!annul_i) begin
                  quotient_q  <= '0;
                  remainder_q <= '0;
                  div_zero_q  <= 1'b1;
               end
            end
            DIV_ON: begin
               if (!annul_i) begin
                  rem_q <= step_rem;
                  quo_q <= step_quo;
                  cnt   <= cnt + CNT_W'(1);
                  if (cnt == LAST_CNT) begin
                     quotient_q  <= neg_quo_q ? -step_quo : step_quo;
                     remainder_q <= neg_rem_q ? -step_rem[WIDTH-1:0]
                                              : step_rem[WIDTH-1:0];
                     div_zero_q  <= 1'b0;
                  end
               end
            end
            DIV_END: begin
               if (annul_i || start_i == DivStop) begin
                  quotient_q  <= '0;
                  remainder_q <= '0;
                  div_zero_q  <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

   assign quotient_o  = quotient_q;
   assign remainder_o = remainder_q;
   assign div_zero_o  = div_zero_q;

endmodule

// File: tb/tb_div_unit.sv
// tb/tb_div_unit.sv - directed self-checking bench for div_unit
module tb_div_unit;

   localparam int WIDTH = 32;
   localparam int LAT_NZ = WIDTH + 1;
   localparam int LAT_Z  = 2;
   localparam int LIMIT  = 60;

   logic             clk = 1'b0;
   logic             rst;
   logic             start_i;
   logic             annul_i;
   logic             signed_i;
   logic [WIDTH-1:0] dividend_i;
   logic [WIDTH-1:0] divisor_i;
   logic             busy_o;
   logic             ready_o;
   logic [WIDTH-1:0] quotient_o;
   logic [WIDTH-1:0] remainder_o;
   logic             div_zero_o;

   int passed = 0;
   int total  = 0;

   div_unit #(.WIDTH(WIDTH)) dut (
      .clk         (clk),
      .rst         (rst),
      .start_i     (start_i),
      .annul_i     (annul_i),
      .signed_i    (signed_i),
      .dividend_i  (dividend_i),
      .divisor_i   (divisor_i),
      .busy_o      (busy_o),
      .ready_o     (ready_o),
      .quotient_o  (quotient_o),
      .remainder_o (remainder_o),
      .div_zero_o  (div_zero_o)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Accepts one operation (start dropped after accept), scrambles the operand
   // inputs every cycle, and reports latency in edges counting the accept edge.
   task automatic run_div(input logic sgn, input logic [WIDTH-1:0] a,
                          input logic [WIDTH-1:0] b, output int lat,
                          output logic [WIDTH-1:0] q, output logic [WIDTH-1:0] r,
                          output logic dz);
      start_i = 1'b1; signed_i = sgn; dividend_i = a; divisor_i = b;
      tick();
      lat = 1;
      start_i = 1'b0;
      while (!ready_o && lat < LIMIT) begin
         dividend_i = $urandom;
         divisor_i  = $urandom;
         signed_i   = ~signed_i;
         tick();
         lat++;
      end
      q = quotient_o; r = remainder_o; dz = div_zero_o;
      tick();
   endtask

   task automatic test_reset();
      rst = 1'b1; start_i = 1'b1; annul_i = 1'b0; signed_i = 1'b0;
      dividend_i = 32'd100; divisor_i = 32'd7;
      tick(); tick();
      total++;
      if ({busy_o, ready_o, div_zero_o} !== 3'b000 || quotient_o !== '0 || remainder_o !== '0)
         $display("FAIL reset_state: busy=%b ready=%b q=%h r=%h dz=%b, required all 0",
                  busy_o, ready_o, quotient_o, remainder_o, div_zero_o);
      else passed++;
      start_i = 1'b0;
      rst = 1'b0;
      tick();
   endtask

   task automatic test_unsigned_hold();
      int lat;
      logic early;
      early = 1'b0;
      start_i = 1'b1; signed_i = 1'b0; dividend_i = 32'd100; divisor_i = 32'd7;
      tick();
      lat = 1;
      while (!ready_o && lat < LIMIT) begin
         if (busy_o !== 1'b1) early = 1'b1;
         tick();
         lat++;
      end
      total++;
      if (lat !== LAT_NZ || early)
         $display("FAIL udiv_latency: ready at edge %0d busy_gap=%b, required %0d", lat, early, LAT_NZ);
      else passed++;
      total++;
      if (quotient_o !== 32'd14 || remainder_o !== 32'd2 || div_zero_o !== 1'b0)
         $display("FAIL udiv_100_7: q=%0d r=%0d dz=%b, required 14 2 0", quotient_o, remainder_o, div_zero_o);
      else passed++;
      tick();
      total++;
      if (ready_o !== 1'b1 || busy_o !== 1'b1 || quotient_o !== 32'd14 || remainder_o !== 32'd2)
         $display("FAIL end_hold: ready=%b busy=%b q=%0d r=%0d, required 1 1 14 2", ready_o, busy_o, quotient_o, remainder_o);
      else passed++;
      start_i = 1'b0;
      tick();
      total++;
      if (busy_o !== 1'b0 || ready_o !== 1'b0 || quotient_o !== '0 || remainder_o !== '0)
         $display("FAIL end_release: busy=%b ready=%b q=%h r=%h, required idle zeros", busy_o, ready_o, quotient_o, remainder_o);
      else passed++;
   endtask

   task automatic test_signed();
      int lat; logic [WIDTH-1:0] q, r; logic dz;
      run_div(1'b1, 32'hFFFF_FFF9, 32'd2, lat, q, r, dz);
      total++;
      if (q !== 32'hFFFF_FFFD || r !== 32'hFFFF_FFFF || lat !== LAT_NZ)
         $display("FAIL sdiv_m7_2: q=%h r=%h lat=%0d, required fffffffd ffffffff %0d", q, r, lat, LAT_NZ);
      else passed++;
      run_div(1'b1, 32'd7, 32'hFFFF_FFFE, lat, q, r, dz);
      total++;
      if (q !== 32'hFFFF_FFFD || r !== 32'd1)
         $display("FAIL sdiv_7_m2: q=%h r=%h, required fffffffd 00000001", q, r);
      else passed++;
      run_div(1'b1, 32'hFFFF_FF9C, 32'hFFFF_FFF9, lat, q, r, dz);
      total++;
      if (q !== 32'd14 || r !== 32'hFFFF_FFFE)
         $display("FAIL sdiv_m100_m7: q=%h r=%h, required 0000000e fffffffe", q, r);
      else passed++;
      run_div(1'b0, 32'hFFFF_FFFF, 32'h10, lat, q, r, dz);
      total++;
      if (q !== 32'h0FFF_FFFF || r !== 32'hF)
         $display("FAIL udiv_max_16: q=%h r=%h, required 0fffffff 0000000f", q, r);
      else passed++;
   endtask

   task automatic test_overflow();
      int lat; logic [WIDTH-1:0] q, r; logic dz;
      run_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, lat, q, r, dz);
      total++;
      if (q !== 32'h8000_0000 || r !== 32'd0 || dz !== 1'b0)
         $display("FAIL sdiv_min_m1: q=%h r=%h dz=%b, required 80000000 0 0", q, r, dz);
      else passed++;
      run_div(1'b0, 32'h8000_0000, 32'hFFFF_FFFF, lat, q, r, dz);
      total++;
      if (q !== 32'd0 || r !== 32'h8000_0000)
         $display("FAIL udiv_min_max: q=%h r=%h, required 0 80000000", q, r);
      else passed++;
   endtask

   task automatic test_zero_divisor();
      int lat; logic [WIDTH-1:0] q, r; logic dz;
      run_div(1'b0, 32'd5, 32'd0, lat, q, r, dz);
      total++;
      if (lat !== LAT_Z || dz !== 1'b1 || q !== '0 || r !== '0)
         $display("FAIL div_zero: lat=%0d dz=%b q=%h r=%h, required %0d 1 0 0", lat, dz, q, r, LAT_Z);
      else passed++;
      total++;
      if (busy_o !== 1'b0 || div_zero_o !== 1'b0)
         $display("FAIL div_zero_release: busy=%b dz=%b, required 0 0", busy_o, div_zero_o);
      else passed++;
   endtask

   task automatic test_annul();
      int lat; logic [WIDTH-1:0] q, r; logic dz; logic seen;
      start_i = 1'b1; signed_i = 1'b0; dividend_i = 32'd100; divisor_i = 32'd7;
      tick();
      start_i = 1'b0;
      for (int i = 2; i < 10; i++) tick();
      annul_i = 1'b1;
      tick();
      annul_i = 1'b0;
      total++;
      if (busy_o !== 1'b0)
         $display("FAIL annul_busy: busy=%b, required 0", busy_o);
      else passed++;
      seen = 1'b0;
      for (int i = 0; i < 40; i++) begin
         if (ready_o !== 1'b0 || busy_o !== 1'b0) seen = 1'b1;
         tick();
      end
      total++;
      if (seen)
         $display("FAIL annul_no_ready: activity after annul=%b, required 0", seen);
      else passed++;
      run_div(1'b0, 32'd9, 32'd3, lat, q, r, dz);
      total++;
      if (q !== 32'd3 || r !== 32'd0 || lat !== LAT_NZ)
         $display("FAIL after_annul_9_3: q=%0d r=%0d lat=%0d, required 3 0 %0d", q, r, lat, LAT_NZ);
      else passed++;
   endtask

   task automatic test_end_annul();
      int lat;
      start_i = 1'b1; signed_i = 1'b0; dividend_i = 32'd9; divisor_i = 32'd3;
      tick();
      lat = 1;
      while (!ready_o && lat < LIMIT) begin tick(); lat++; end
      annul_i = 1'b1;
      tick();
      annul_i = 1'b0; start_i = 1'b0;
      total++;
      if (busy_o !== 1'b0 || ready_o !== 1'b0 || quotient_o !== '0 || lat !== LAT_NZ)
         $display("FAIL end_annul: busy=%b ready=%b q=%h lat=%0d, required 0 0 0 %0d", busy_o, ready_o, quotient_o, lat, LAT_NZ);
      else passed++;
      tick();
   endtask

   task automatic test_reset_mid();
      int lat; logic [WIDTH-1:0] q, r; logic dz; logic seen;
      start_i = 1'b1; signed_i = 1'b0; dividend_i = 32'd100; divisor_i = 32'd7;
      tick();
      start_i = 1'b0;
      for (int i = 2; i < 20; i++) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      total++;
      if ({busy_o, ready_o, div_zero_o} !== 3'b000 || quotient_o !== '0 || remainder_o !== '0)
         $display("FAIL reset_mid: busy=%b ready=%b q=%h r=%h dz=%b, required all 0",
                  busy_o, ready_o, quotient_o, remainder_o, div_zero_o);
      else passed++;
      seen = 1'b0;
      for (int i = 0; i < 40; i++) begin
         if (ready_o !== 1'b0) seen = 1'b1;
         tick();
      end
      total++;
      if (seen)
         $display("FAIL reset_no_ready: ready seen=%b, required 0", seen);
      else passed++;
      run_div(1'b0, 32'd100, 32'd7, lat, q, r, dz);
      total++;
      if (q !== 32'd14 || r !== 32'd2 || lat !== LAT_NZ)
         $display("FAIL after_reset_100_7: q=%0d r=%0d lat=%0d, required 14 2 %0d", q, r, lat, LAT_NZ);
      else passed++;
   endtask

   task automatic test_start_ignored();
      int lat;
      start_i = 1'b1; signed_i = 1'b0; dividend_i = 32'd1000; divisor_i = 32'd33;
      tick();
      lat = 1;
      while (!ready_o && lat < LIMIT) begin
         start_i = lat[0];
         dividend_i = $urandom;
         tick();
         lat++;
      end
      total++;
      if (quotient_o !== 32'd30 || remainder_o !== 32'd10 || lat !== LAT_NZ)
         $display("FAIL start_ignored: q=%0d r=%0d lat=%0d, required 30 10 %0d", quotient_o, remainder_o, lat, LAT_NZ);
      else passed++;
      start_i = 1'b0;
      tick();
   endtask

   initial begin
      test_reset();
      test_unsigned_hold();
      test_signed();
      test_overflow();
      test_zero_divisor();
      test_annul();
      test_end_annul();
      test_reset_mid();
      test_start_ignored();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/div_unit.md
DIV_UNIT -- requirements
Module: div_unit

Interface
REQ-001 Parameter WIDTH, default 32: operand, quotient and remainder width; legal values are 8 to 64.
REQ-002 Parameter CNT_W, default $clog2(WIDTH)+1: width of the iteration counter.
REQ-003 Port clk, input, 1: rising-edge clock.
REQ-004 Port rst, input, 1: reset. Synchronous, active-high.
REQ-005 Port start_i, input, 1: divide request from the execute stage.
REQ-006 Port annul_i, input, 1: cancel the operation in flight (flush or exception).
REQ-007 Port signed_i, input, 1: 1 selects two's-complement (DIV); 0 selects unsigned (DIVU).
REQ-008 Port dividend_i, input, WIDTH: dividend, sampled only on the accept edge.
REQ-009 Port divisor_i, input, WIDTH: divisor, sampled only on the accept edge.
REQ-010 Port busy_o, output, 1: high in every state except IDLE; the execute stage uses it as its stall request.
REQ-011 Port ready_o, output, 1: result valid; high only while in END.
REQ-012 Port quotient_o, output, WIDTH: quotient, destined for LO.
REQ-013 Port remainder_o, output, WIDTH: remainder, destined for HI.
REQ-014 Port div_zero_o, output, 1: the result came from a zero divisor; valid only with ready_o.

Function
REQ-015 The unit SHALL implement states IDLE, BYZERO, ON and END, all registered.
REQ-016 Accept: in IDLE, with start_i=1 and annul_i=0 at an edge:
- operands and signed_i are latched;
- next state is BYZERO if divisor_i==0, otherwise ON.
REQ-017 Input changes after the accept edge SHALL have no effect on the operation in flight.
REQ-018 Signed mode: each negative operand SHALL be converted to its magnitude before iteration.
REQ-019 ON SHALL perform one restoring shift-subtract step per cycle, for exactly WIDTH cycles.
- the counter runs 0 to WIDTH-1;
- the partial remainder is WIDTH+1 bits wide.
REQ-020 After the final step, the next state SHALL be END, with results registered in the same edge.
REQ-021 Result timing: ready_o rises WIDTH+1 edges after the accept edge for a non-zero divisor, and 2 edges after the accept edge (through BYZERO) for a zero divisor.
REQ-022 Signed result fixup:
- quotient is negated when the operand signs differ;
- remainder takes the sign of the dividend.
REQ-023 Signed minimum / -1 SHALL give quotient = minimum value and remainder = 0 (wrap, no trap).
REQ-024 Zero divisor: quotient_o=0, remainder_o=0, div_zero_o=1.
REQ-025 END SHALL hold ready_o and the results stable while start_i=1, and return to IDLE on the first edge with start_i=0.
REQ-026 annul_i=1 in BYZERO or ON SHALL return the unit to IDLE on that edge; ready_o never asserts for the annulled operation.
REQ-027 annul_i=1 in END SHALL return the unit to IDLE on that edge.
REQ-028 start_i SHALL be ignored while the unit is in BYZERO or ON.
REQ-029 Outside END: quotient_o, remainder_o and div_zero_o SHALL read 0.
REQ-030 Each state SHALL give busy_o/ready_o as follows: IDLE 0/0, BYZERO 1/0, ON 1/0, END 1/1.

Reset
REQ-031 rst=1 at an edge SHALL force IDLE and clear the counter, the operand registers and every output to 0; this takes priority over start_i and annul_i.
REQ-032 rst asserted mid-operation SHALL abort the operation with no ready_o pulse; the first start_i after rst is released is accepted normally.

Structure
REQ-033 The shared define package SHALL hold:
- the state encodings DIV_IDLE, DIV_BYZERO, DIV_ON, DIV_END;
- DivStart, DivStop and the signed/unsigned select constants.
REQ-034 Each iteration (compare, conditional subtract, shift) SHALL be a combinational sub-module named div_step, parametrised by WIDTH.
REQ-035 HI/LO write-back muxing and the stall network SHALL stay in the execute stage, outside this module.

Verification (WIDTH=32)
REQ-036 Unsigned: 100 / 7 with start held -> at accept+33, ready_o=1, quotient 14, remainder 2, div_zero 0; then start dropped -> IDLE next edge.
REQ-037 Signed: 0xFFFFFFF9 / 2 -> quotient 0xFFFFFFFD, remainder 0xFFFFFFFF; signed 7 / 0xFFFFFFFE -> quotient 0xFFFFFFFD, remainder 1.
REQ-038 Zero divisor: 5 / 0 -> ready_o at accept+2, div_zero_o=1, quotient 0, remainder 0.
REQ-039 Overflow: signed 0x80000000 / 0xFFFFFFFF -> quotient 0x80000000, remainder 0; unsigned same operands -> quotient 0, remainder 0x80000000.
REQ-040 Annul: annul_i pulsed at accept+10 -> busy_o low at the next edge, no ready_o; a new 9 / 3 start then gives quotient 3, remainder 0.
REQ-041 Reset and operand isolation:
- rst at accept+20 -> all outputs 0, IDLE;
- operand inputs toggled during ON -> the result is unaffected.
